mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle cpu_control so that one ALU and one unified memory port are shared across the fetch, decode, execute, memory and writeback phases. Each cycle it decodes op and funct, drives every mux select and write enable, and stalls on a memory ready handshake. Bus timeouts and illegal opcodes trap the core.

Parameters:
MEM_TIMEOUT, 15, maximum consecutive cycles a memory state may wait for mem_ready before a bus error is declared (1..255).
STATE_W, 4, width of the state register and of the state debug output.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
op  input  6  instruction[31:26] from the instruction register
funct  input  6  instruction[5:0] from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed the current read or write this cycle
pc_write  output  1  load PC
ir_write  output  1  load instruction register
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read_enable  output  1  memory read strobe
mem_write_enable  output  1  memory write strobe
mem_to_reg  output  1  register write data select: 0 = ALUOut, 1 = memory data register
reg_dest  output  1  write register select: 0 = rt, 1 = rd
reg_write_enable  output  1  register file write
alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
alu_src_b  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
alu_op  output  3  ALU operation: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR
pc_src  output  2  PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  output  1  sticky trap flag for an unknown op or funct
bus_error  output  1  sticky trap flag for a memory timeout
state  output  STATE_W  current state, for debug
retired_count  output  32  number of retired instructions (see Optional Feature)

Behaviour:
- Reset is synchronous. On reset: state = FETCH, wait counter = 0, illegal_op = 0, bus_error = 0, retired_count = 0.
- While reset is high, all enables and write strobes are 0. All selects are 0.
- Outputs are combinational from the registered state. pc_write and ir_write in FETCH also depend on mem_ready; pc_write in BRANCH also depends on zero. Any output not listed for a state is 0.
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, bne = 000101, j = 000010, addi = 001000.
- R-type funct to alu_op: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
- States and transitions:
  - FETCH (0): i_or_d=0, mem_read_enable=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00. ir_write and pc_write equal mem_ready. Go to DECODE when mem_ready=1, otherwise stay.
  - DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes the branch target). Dispatch on op: lw/sw to MEM_ADDR, R to R_EXEC, beq/bne to BRANCH, j to JUMP, addi to I_EXEC, anything else to TRAP with illegal_op set.
  - MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=ADD. Go to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ (3): i_or_d=1, mem_read_enable=1. Go to MEM_WB when mem_ready=1.
  - MEM_WB (4): reg_dest=0, mem_to_reg=1, reg_write_enable=1. Go to FETCH.
  - MEM_WRITE (5): i_or_d=1, mem_write_enable=1. Go to FETCH when mem_ready=1.
  - R_EXEC (6): alu_src_a=1, alu_src_b=00, alu_op from funct. An unknown funct goes to TRAP with illegal_op set; otherwise go to R_WB.
  - R_WB (7): reg_dest=1, mem_to_reg=0, reg_write_enable=1, alu_op held from funct. Go to FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01. pc_write = zero for beq, ~zero for bne. Go to FETCH.
  - JUMP (9): pc_src=10, pc_write=1. Go to FETCH.
  - I_EXEC (10): alu_src_a=1, alu_src_b=10, alu_op=ADD. Go to I_WB.
  - I_WB (11): reg_dest=0, mem_to_reg=0, reg_write_enable=1. Go to FETCH.
  - TRAP (12): all enables 0. Stays in TRAP until reset.
- Latency with zero-wait memory: lw 5 cycles; sw, R and addi 4 cycles; beq, bne and j 3 cycles.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP and bus_error is set.
  - If mem_ready=1 arrives on the same cycle the limit is reached, mem_ready wins and there is no error.
- Unused state encodings 13 to 15 go to TRAP with illegal_op set.
- Reset asserted mid-instruction aborts it: no further writes occur, and the core restarts in FETCH.

Optional Feature:
INSTR_COUNT_EN.
- Defined: retired_count increments by 1, with 32-bit wrap, on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or I_WB. TRAP entries do not count.
- Undefined: retired_count is tied to 0 and no counter register is built.

Test Plan:
- Zero-wait memory; sequence addi, add, lw, sw, beq (taken, zero=1), j -> state traces 0,1,10,11 / 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,9. pc_write asserted in the BRANCH cycle. With INSTR_COUNT_EN, retired_count=6.
- bne with zero=1 -> pc_write=0 in BRANCH. bne with zero=0 -> pc_write=1 and pc_src=01.
- lw with mem_ready held low 3 cycles in MEM_READ -> state stays 3 for 4 cycles and mem_read_enable stays 1. MEM_WB follows; no bus_error.
- mem_ready held low in FETCH with MEM_TIMEOUT=15 -> after 15 waiting cycles the state becomes 12 and bus_error=1. Raising mem_ready afterwards has no effect. Asserting reset returns state to 0 and clears bus_error.
- op=111111, then separately R-type with funct=000001 -> TRAP with illegal_op=1, and reg_write_enable is never asserted.
- reset pulsed during MEM_WRITE with mem_ready=0 -> mem_write_enable=0 in the reset cycle. The next cycle is state 0 with all flags 0.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control sequencer: one shared ALU and one unified memory port.
// Latency: lw 5, sw/R/addi 4, beq/bne/j 3 cycles with zero-wait memory; outputs are combinational from state.
// Backpressure: FETCH/MEM_READ/MEM_WRITE stall on mem_ready; MEM_TIMEOUT stalled cycles trap with bus_error.
//
// Ports: clk/reset (sync, active-high); op/funct from IR; zero from ALU; mem_ready handshake.
//   Datapath controls: pc_write, ir_write, i_or_d, mem_read_enable, mem_write_enable, mem_to_reg,
//   reg_dest, reg_write_enable, alu_src_a, alu_src_b, alu_op, pc_src.
//   Status: illegal_op, bus_error (sticky until reset), state (debug), retired_count.
// Optional macro INSTR_COUNT_EN: builds the retired-instruction counter; otherwise retired_count is 0.
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read_enable,
  output logic               mem_write_enable,
  output logic               mem_to_reg,
  output logic               reg_dest,
  output logic               reg_write_enable,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic               bus_error,
  output logic [STATE_W-1:0] state,
  output logic [31:0]        retired_count
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC,
    R_WB, BRANCH, JUMP, I_EXEC, I_WB, TRAP
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b110;
  localparam logic [2:0] ALU_OR  = 3'b111;

  // Last count value at which a still-stalled memory state gives up.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur_state, next_state;
  logic [7:0] wait_cnt;
  logic       set_illegal, set_bus_err;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       mem_wait;

  assign state = cur_state;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b100110: funct_alu = ALU_XOR;
      6'b100111: funct_alu = ALU_NOR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  assign mem_wait = ((cur_state == FETCH) || (cur_state == MEM_READ) ||
                     (cur_state == MEM_WRITE)) && !mem_ready;

  always_comb begin
    next_state  = cur_state;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (cur_state)
      FETCH:     if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:    next_state = MEM_ADDR;
          OP_R:            next_state = R_EXEC;
          OP_BEQ, OP_BNE:  next_state = BRANCH;
          OP_J:            next_state = JUMP;
          OP_ADDI:         next_state = I_EXEC;
          default: begin
            next_state  = TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        if (op == OP_LW)      next_state = MEM_READ;
        else if (op == OP_SW) next_state = MEM_WRITE;
        else begin
          next_state  = TRAP;
          set_illegal = 1'b1;
        end
      end
      MEM_READ:  if (mem_ready) next_state = MEM_WB;
      MEM_WB:    next_state = FETCH;
      MEM_WRITE: if (mem_ready) next_state = FETCH;
      R_EXEC: begin
        if (funct_ok) next_state = R_WB;
        else begin
          next_state  = TRAP;
          set_illegal = 1'b1;
        end
      end
      R_WB:      next_state = FETCH;
      BRANCH:    next_state = FETCH;
      JUMP:      next_state = FETCH;
      I_EXEC:    next_state = I_WB;
      I_WB:      next_state = FETCH;
      TRAP:      next_state = TRAP;
      default: begin
        next_state  = TRAP;
        set_illegal = 1'b1;
      end
    endcase
    // A stall that has used up its budget overrides the hold above; mem_ready
    // on the final cycle keeps mem_wait low, so a late completion still wins.
    if (mem_wait && (wait_cnt == TIMEOUT_LAST)) begin
      next_state  = TRAP;
      set_bus_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= FETCH;
      wait_cnt   <= 8'd0;
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (next_state != cur_state) wait_cnt <= 8'd0;
      else if (mem_wait)           wait_cnt <= wait_cnt + 8'd1;
      if (set_illegal) illegal_op <= 1'b1;
      if (set_bus_err) bus_error  <= 1'b1;
    end
  end

`ifdef INSTR_COUNT_EN
  logic retire;
  // Every normal completion re-enters FETCH; only reset leaves TRAP.
  assign retire = (next_state == FETCH) &&
                  ((cur_state == MEM_WB) || (cur_state == MEM_WRITE) ||
                   (cur_state == R_WB)   || (cur_state == BRANCH)    ||
                   (cur_state == JUMP)   || (cur_state == I_WB));

  always_ff @(posedge clk) begin
    if (reset)       retired_count <= 32'd0;
    else if (retire) retired_count <= retired_count + 32'd1;
  end
`else
  assign retired_count = 32'd0;
`endif

  // Reset forces every control low so an aborted instruction cannot write.
  always_comb begin
    pc_write         = 1'b0;
    ir_write         = 1'b0;
    i_or_d           = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_to_reg       = 1'b0;
    reg_dest         = 1'b0;
    reg_write_enable = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'b00;
    alu_op           = ALU_ADD;
    pc_src           = 2'b00;
    if (!reset) begin
      case (cur_state)
        FETCH: begin
          mem_read_enable = 1'b1;
          alu_src_b       = 2'b01;
          ir_write        = mem_ready;
          pc_write        = mem_ready;
        end
        DECODE:    alu_src_b = 2'b11;
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_READ: begin
          i_or_d          = 1'b1;
          mem_read_enable = 1'b1;
        end
        MEM_WB: begin
          mem_to_reg       = 1'b1;
          reg_write_enable = 1'b1;
        end
        MEM_WRITE: begin
          i_or_d           = 1'b1;
          mem_write_enable = 1'b1;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = funct_alu;
        end
        R_WB: begin
          reg_dest         = 1'b1;
          reg_write_enable = 1'b1;
          alu_op           = funct_alu;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = 2'b01;
          pc_write  = (op == OP_BNE) ? !zero : zero;
        end
        JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        I_WB:      reg_write_enable = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
